// File: rtl/serial_to_parallel_reg.sv
// Bit-serial (LSB first) to parallel word assembler with a start-framed input,
// double-buffered valid/ready output and a sticky overrun flag for dropped words.
module serial_to_parallel_reg #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             D,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Q,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] word;
  logic             done;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sreg_d      = sreg_q;
    q_d         = q_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    done        = 1'b0;
    word        = {D, sreg_q[WIDTH-1:1]};

    unique case (state_q)
      IDLE: begin
        if (en && start) begin
          sreg_d  = word;
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (en) begin
          sreg_d = word;
          // A start mid-frame restarts the count; stale bits shift out naturally.
          if (start) begin
            cnt_d = CW'(1);
          end else if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_d   = '0;
            state_d = IDLE;
            done    = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Completion may overwrite Q only if the held word is free or leaving now.
    if (done) begin
      if (!out_valid_q || out_ready) begin
        q_d         = word;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sreg_q      <= '0;
      q_q         <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sreg_q      <= sreg_d;
      q_q         <= q_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign Q         = q_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == SHIFT);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_serial_to_parallel_reg.sv
// Self-checking bench for serial_to_parallel_reg: vector table, directed frame
// sequences and a randomized run against a bit-queue reference model.
module tb_serial_to_parallel_reg;
  localparam int W = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b0, en = 1'b0, start = 1'b0, d = 1'b0, rdy = 1'b0;
  logic [W-1:0] q;
  logic         ov, busy, ovr;

  int n_chk = 0, n_fail = 0;

  // Reference model: collected bits of the current frame plus output buffer.
  bit           m_infr;
  bit           m_bits[$];
  logic [W-1:0] m_q;
  bit           m_v, m_o;

  serial_to_parallel_reg #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .D(d), .out_ready(rdy),
    .Q(q), .out_valid(ov), .busy(busy), .overrun(ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit e, input bit s, input bit dd, input bit r, input bit rs);
    bit           fin;
    logic [W-1:0] wd;
    fin = 0;
    wd  = '0;
    if (!rs) begin
      m_infr = 0; m_bits.delete(); m_q = '0; m_v = 0; m_o = 0;
    end else begin
      if (e) begin
        if (s) begin
          m_bits.delete(); m_bits.push_back(dd); m_infr = 1;
        end else if (m_infr) begin
          m_bits.push_back(dd);
          if (m_bits.size() == W) begin
            for (int i = 0; i < W; i++) wd = wd + (W'(m_bits[i]) << i);
            fin = 1; m_infr = 0; m_bits.delete();
          end
        end
      end
      if (fin) begin
        if (!m_v || r) begin m_q = wd; m_v = 1; end
        else m_o = 1;
      end else if (m_v && r) m_v = 0;
    end
  endtask

  task automatic cyc(input bit e, input bit s, input bit dd, input bit r, input bit rs);
    en = e; start = s; d = dd; rdy = r; rst = rs;
    @(posedge clk);
    #1;
    model_step(e, s, dd, r, rs);
    chk("model_q", q, m_q);
    chk("model_out_valid", ov, m_v);
    chk("model_busy", busy, m_infr);
    chk("model_overrun", ovr, m_o);
  endtask

  // mode: 0 out_ready low, 1 out_ready high, 2 high only on the final bit
  task automatic send_word(input logic [W-1:0] w, input int mode, input int g1, input int g2,
                           output int ncyc);
    ncyc = 0;
    for (int i = 0; i < W; i++) begin
      if (i == 6)  repeat (g1) begin cyc(0, 0, 0, 0, 1); ncyc++; end
      if (i == 14) repeat (g2) begin cyc(0, 0, 0, 0, 1); ncyc++; end
      cyc(1, i == 0, w[i], (mode == 1) || (mode == 2 && i == W - 1), 1);
      ncyc++;
    end
  endtask

  typedef struct {
    bit e, s, dd, r, rs;
    logic [W-1:0] eq;
    bit ev, eb, eo;
  } vec_t;

  vec_t vt[7];
  int   nc;

  initial begin
    vt[0] = '{e:0, s:0, dd:0, r:0, rs:0, eq:'0, ev:0, eb:0, eo:0}; // reset
    vt[1] = '{e:1, s:0, dd:1, r:0, rs:1, eq:'0, ev:0, eb:0, eo:0}; // bit w/o start ignored
    vt[2] = '{e:0, s:1, dd:1, r:0, rs:1, eq:'0, ev:0, eb:0, eo:0}; // start w/o en ignored
    vt[3] = '{e:1, s:0, dd:1, r:1, rs:1, eq:'0, ev:0, eb:0, eo:0}; // ready while empty
    vt[4] = '{e:1, s:1, dd:1, r:0, rs:1, eq:'0, ev:0, eb:1, eo:0}; // frame begins
    vt[5] = '{e:0, s:0, dd:0, r:0, rs:1, eq:'0, ev:0, eb:1, eo:0}; // gap holds
    vt[6] = '{e:1, s:0, dd:1, r:0, rs:0, eq:'0, ev:0, eb:0, eo:0}; // reset mid-frame
    for (int i = 0; i < 7; i++) begin
      cyc(vt[i].e, vt[i].s, vt[i].dd, vt[i].r, vt[i].rs);
      chk($sformatf("vec%0d_q", i), q, vt[i].eq);
      chk($sformatf("vec%0d_valid", i), ov, vt[i].ev);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].eb);
      chk($sformatf("vec%0d_ovr", i), ovr, vt[i].eo);
    end

    // Continuous frame, no consumer
    send_word(20'hABCDE, 0, 0, 0, nc);
    chk("abcde_q", q, 20'hABCDE);
    chk("abcde_valid", ov, 1);
    chk("abcde_busy_after", busy, 0);
    chk("abcde_cycles", nc, W);
    cyc(0, 0, 0, 1, 1);
    chk("abcde_consumed", ov, 0);

    // Same word with gaps
    send_word(20'hABCDE, 0, 3, 3, nc);
    chk("gap_q", q, 20'hABCDE);
    chk("gap_cycles", nc, W + 6);
    cyc(0, 0, 0, 1, 1);
    cyc(1, 0, 1, 0, 1);
    chk("idle_nostart_busy", busy, 0);

    // Back-pressure drops the second word
    send_word(20'h12345, 0, 0, 0, nc);
    send_word(20'h0F0F0, 0, 0, 0, nc);
    chk("drop_q", q, 20'h12345);
    chk("drop_ovr", ovr, 1);
    cyc(0, 0, 0, 1, 1);
    chk("drop_consumed", ov, 0);
    chk("drop_ovr_sticky", ovr, 1);
    cyc(0, 0, 0, 0, 0);
    chk("ovr_cleared", ovr, 0);

    // Completion coincident with consume
    send_word(20'h11111, 0, 0, 0, nc);
    send_word(20'h22222, 2, 0, 0, nc);
    chk("swap_q", q, 20'h22222);
    chk("swap_valid", ov, 1);
    chk("swap_ovr", ovr, 0);
    cyc(0, 0, 0, 1, 1);

    // Resync after partial frame
    for (int i = 0; i < 7; i++) cyc(1, i == 0, 1'(i & 1), 0, 1);
    chk("partial_no_valid", ov, 0);
    send_word(20'hFFFFF, 0, 0, 0, nc);
    chk("resync_q", q, 20'hFFFFF);
    chk("resync_valid", ov, 1);

    // Reset mid-frame with a held word
    for (int i = 0; i < 10; i++) cyc(1, i == 0, 1, 0, 1);
    cyc(1, 0, 1, 0, 0);
    chk("rst_q", q, 0);
    chk("rst_valid", ov, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", ovr, 0);
    send_word(20'h00001, 0, 0, 0, nc);
    chk("post_rst_q", q, 20'h00001);
    chk("post_rst_valid", ov, 1);

    // Randomized run against the model
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0, 1'($urandom),
          $urandom_range(0, 9) < 2, $urandom_range(0, 299) != 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_to_parallel_reg.md
# serial_to_parallel_reg

Bit-serial to parallel word assembler for the DA filter datapath: the receiving end of the LSB-first serial stream produced by the parallel-load shift register. It collects WIDTH bits framed by a start strobe, presents the completed word on a held parallel output with a valid/ready handshake, and flags words lost to back-pressure. It sits wherever a bit-serial result must return to a parallel bus, e.g. filter output capture or loopback checking of the serializer.

## Interface
- WIDTH, 20, word length in bits; legal range 2..64
- clk  input  1  rising-edge clock; single clock domain
- rst  input  1  synchronous reset, active-low (0 = reset), sampled on rising clk
- en  input  1  serial bit valid; D is sampled only when en=1
- start  input  1  frame start; meaningful only with en=1, marks D as bit 0 of a new word
- D  input  1  serial data bit, LSB first
- out_ready  input  1  consumer accepts Q this cycle when out_valid=1
- Q  output  WIDTH  assembled word, held stable while out_valid=1
- out_valid  output  1  Q holds an unconsumed word
- busy  output  1  a frame is in progress (state SHIFT)
- overrun  output  1  sticky: a completed word was dropped; cleared only by reset

## Operation
- Internal: shift register sreg[WIDTH-1:0], bit counter cnt of width clog2(WIDTH), output buffer Q separate from sreg (double buffered; a new frame may assemble while Q is held).
- Every accepted bit shifts in at the MSB: sreg <= {D, sreg[WIDTH-1:1]}; after WIDTH accepted bits, bit 0 of sreg is the first bit received.
- FSM states IDLE, SHIFT.
- IDLE: en=1 and start=1 -> accept D, cnt <= 1, go SHIFT. en=1 with start=0 -> bit ignored, stay IDLE. en=0 -> hold.
- SHIFT: en=0 -> hold everything (gaps of any length allowed). en=1, start=0, cnt < WIDTH-1 -> accept D, cnt++.
- SHIFT, en=1, start=0, cnt = WIDTH-1 -> word complete: word = {D, sreg[WIDTH-1:1]}, cnt <= 0, go IDLE, then delivery rule below.
- SHIFT, en=1, start=1 -> resynchronise: discard partial word, accept D as bit 0, cnt <= 1, stay SHIFT. No flag raised.
- Delivery on completion: if out_valid=0, or out_valid=1 and out_ready=1 in the same cycle -> Q <= word, out_valid stays/becomes 1. If out_valid=1 and out_ready=0 -> word dropped, Q unchanged, overrun <= 1.
- Handshake: out_valid=1 and out_ready=1 with no completion that cycle -> out_valid <= 0; Q keeps its last value. out_ready while out_valid=0 has no effect.
- busy = (state == SHIFT), registered-state decode.

## Timing
- Reset (rst=0 at a rising edge): state IDLE, cnt 0, sreg 0, Q 0, out_valid 0, overrun 0, busy 0. Reset mid-frame or with an unconsumed word discards both; all other inputs ignored that cycle.
- Latency: Q and out_valid update on the same edge that samples the WIDTH-th bit; visible the cycle after that bit is presented.
- Back-to-back frames: start may coincide with the first cycle after completion (state IDLE); with continuous en, one word per WIDTH cycles, zero dead cycles.
- out_valid stays high until the edge where out_ready=1 is sampled; Q never changes while out_valid=1 unless a word completes in the same cycle out_ready=1.
- overrun asserts the cycle after the dropping edge and remains 1 until reset.

## Test plan
- WIDTH=20, rst released, send 20'hABCDE LSB first with start on bit 0, en continuous, out_ready=0 -> out_valid=1 and Q=20'hABCDE exactly one cycle after bit 19; busy=1 during bits 1..19, 0 after.
- Same word with en deasserted for 3 random cycles between bits 5/6 and 13/14 -> identical Q, completion delayed by 6 cycles; en=1 without start in IDLE -> no state change.
- Hold out_ready=0, send 20'h12345 then 20'h0F0F0 -> Q stays 20'h12345, overrun=1 after second word; raise out_ready -> out_valid=0 next cycle.
- out_valid=1 with Q=20'h11111; complete 20'h22222 in the cycle out_ready=1 -> Q=20'h22222, out_valid remains 1, overrun=0.
- Send 7 bits, then start with new word 20'hFFFFF -> Q=20'hFFFFF after 20 further bits, no partial word emitted.
- Assert rst=0 at bit 10 of a frame with out_valid=1 -> next cycle all outputs 0; following complete frame 20'h00001 delivers correctly.
